// File: rtl/meter_ballistics.sv
// meter_ballistics
//   VU-style ballistics for the per-window peak magnitude stream. Each update
//   applies instant attack and exponential release to a 23-bit linear level.
//   The next stage converts that level into an 8-bit log2 code
//   {exponent[4:0], mantissa[2:0]} for the IN-9 bargraph drive.
//
//   Optional feature macro: METER_PEAK_HOLD_EN.
//   When it is defined, a peak-hold marker code is kept. The marker is frozen
//   for HOLD_UPDATES updates and then falls by one code per update.
//   Without the macro, hold_code is tied to 0.
//
// Parameters
//   RELEASE_SHIFT : release coefficient; a release subtracts level>>RELEASE_SHIFT (1..8)
//   HOLD_UPDATES  : updates the hold marker stays frozen (1..255)
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   vin        in   one-cycle strobe, new peak magnitude on din
//   din        in   23-bit unsigned peak magnitude
//   vout       out  one-cycle strobe, level_code/hold_code updated
//   level      out  current smoothed linear level (stage 1)
//   level_code out  log2 code of level (stage 2)
//   hold_code  out  peak-hold marker code
module meter_ballistics #(
  parameter int RELEASE_SHIFT = 4,
  parameter int HOLD_UPDATES  = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vin,
  input  logic [22:0] din,
  output logic        vout,
  output logic [22:0] level,
  output logic [7:0]  level_code,
  output logic [7:0]  hold_code
);

  // Log2 code: p = index of the leading one, m = next three bits below it.
  // Shifting the leading one up to bit 22 gives zero padding for p<3.
  function automatic logic [7:0] log2_code(input logic [22:0] v);
    logic [4:0]  p;
    logic [22:0] n;
    p = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (v[i]) begin
        p = i[4:0];
      end else begin
        p = p;
      end
    end
    n = v << (5'd22 - p);
    if (v == 23'd0) begin
      return 8'd0;
    end else begin
      return {p, n[21:19]};
    end
  endfunction

  logic        v1_q, v1_d;
  logic [22:0] level_q, level_d;
  logic [22:0] dec_s;
  logic        vout_q, vout_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  code_s;

  // Stage 1: attack / release on each strobe.
  always_comb begin
    v1_d    = vin;
    level_d = level_q;
    dec_s   = level_q >> RELEASE_SHIFT;
    if (vin) begin
      if (din > level_q) begin
        level_d = din;
      end else if ((dec_s == 23'd0) && (level_q != 23'd0)) begin
        // Small levels would never decay with a pure shift; step down by one instead.
        level_d = level_q - 23'd1;
      end else begin
        level_d = level_q - dec_s;
      end
    end else begin
      level_d = level_q;
    end
  end

  // Stage 2: log conversion of the stage-1 level and the output strobe.
  always_comb begin
    code_s = log2_code(level_q);
    vout_d = v1_q;
    if (v1_q) begin
      code_d = code_s;
    end else begin
      code_d = code_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      level_q <= 23'd0;
      vout_q  <= 1'b0;
      code_q  <= 8'd0;
    end else begin
      v1_q    <= v1_d;
      level_q <= level_d;
      vout_q  <= vout_d;
      code_q  <= code_d;
    end
  end

`ifdef METER_PEAK_HOLD_EN
  logic [7:0] hold_q, hold_d;
  logic [7:0] timer_q, timer_d;

  // Peak-hold marker: it follows rising codes and freezes for HOLD_UPDATES
  // updates. After that it falls one code per update. The marker is only
  // decremented while it is strictly above the new code, so it can never
  // fall below that code.
  always_comb begin
    hold_d  = hold_q;
    timer_d = timer_q;
    if (v1_q) begin
      if (code_s >= hold_q) begin
        hold_d  = code_s;
        timer_d = 8'(HOLD_UPDATES);
      end else if (timer_q != 8'd0) begin
        timer_d = timer_q - 8'd1;
      end else begin
        hold_d = hold_q - 8'd1;
      end
    end else begin
      hold_d  = hold_q;
      timer_d = timer_q;
    end
  end

  // Hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= 8'd0;
      timer_q <= 8'd0;
    end else begin
      hold_q  <= hold_d;
      timer_q <= timer_d;
    end
  end

  assign hold_code = hold_q;
`else
  assign hold_code = 8'd0;
`endif

  assign vout       = vout_q;
  assign level      = level_q;
  assign level_code = code_q;

endmodule

// File: tb/tb_meter_ballistics.sv
module tb_meter_ballistics;

  logic        clk;
  logic        rst;
  logic        vin;
  logic [22:0] din;
  logic        vout;
  logic [22:0] level;
  logic [7:0]  level_code;
  logic [7:0]  hold_code;

  int n_tests;
  int n_fail;

  // Reference state
  logic [22:0] m_level;
  logic [7:0]  m_hold;
  logic [7:0]  m_timer;

  localparam int HOLD = 2;

  meter_ballistics #(.RELEASE_SHIFT(4), .HOLD_UPDATES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .vin        (vin),
    .din        (din),
    .vout       (vout),
    .level      (level),
    .level_code (level_code),
    .hold_code  (hold_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  // Independent log2 code: find the leading one, then pick the bits below it one at a time.
  function automatic logic [7:0] ref_code(input logic [22:0] v);
    int p;
    logic [2:0] m;
    if (v == 23'd0) return 8'd0;
    p = 0;
    for (int i = 22; i >= 0; i--) if (v[i] && p == 0 && i != 0) begin p = i; break; end
    m = 3'd0;
    for (int j = 1; j <= 3; j++) if (p - j >= 0) m[3-j] = v[p-j];
    return 8'(p * 8 + m);
  endfunction

  function automatic logic [22:0] ref_level(input logic [22:0] cur, input logic [22:0] d);
    logic [22:0] dec;
    if (d > cur) return d;
    dec = cur / 23'd16;
    if (dec == 23'd0) return (cur == 23'd0) ? 23'd0 : cur - 23'd1;
    return cur - dec;
  endfunction

  task automatic model_reset();
    m_level = 23'd0;
    m_hold  = 8'd0;
    m_timer = 8'd0;
  endtask

  task automatic model_hold(input logic [7:0] c);
`ifdef METER_PEAK_HOLD_EN
    if (c >= m_hold) begin
      m_hold  = c;
      m_timer = 8'(HOLD);
    end else if (m_timer != 8'd0) begin
      m_timer = m_timer - 8'd1;
    end else begin
      m_hold = m_hold - 8'd1;
    end
`else
    m_hold = 8'd0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vin = 1'b0; din = 23'd0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One update, then check level after stage 1 and vout/code/hold after stage 2.
  task automatic send(input logic [22:0] d);
    @(negedge clk);
    vin = 1'b1; din = d;
    @(negedge clk);
    vin = 1'b0; din = 23'd0;
    m_level = ref_level(m_level, d);
    check("level_s1", 32'(level), 32'(m_level));
    check("vout_early", 32'(vout), 32'd0);
    @(negedge clk);
    model_hold(ref_code(m_level));
    check("vout", 32'(vout), 32'd1);
    check("code", 32'(level_code), 32'(ref_code(m_level)));
    check("hold", 32'(hold_code), 32'(m_hold));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; vin = 1'b0; din = 23'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_vout", 32'(vout), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_code", 32'(level_code), 32'd0);
    check("rst_hold", 32'(hold_code), 32'd0);
    rst = 1'b0;

    // Full scale attack
    send(23'h7FFFFF);
    check("fs_level", 32'(level), 32'h7FFFFF);
    check("fs_code", 32'(level_code), 32'd183);
    @(negedge clk);
    check("vout_one_cycle", 32'(vout), 32'd0);
    // Idle cycles hold everything
    repeat (3) @(negedge clk);
    check("idle_level", 32'(level), 32'h7FFFFF);
    check("idle_code", 32'(level_code), 32'd183);
    check("idle_vout", 32'(vout), 32'd0);

    // Release from 0x400000
    do_reset();
    send(23'h400000);
    check("half_code", 32'(level_code), 32'd176);
    send(23'd0);
    check("rel_level", 32'(level), 32'h3C0000);
    check("rel_code", 32'(level_code), 32'd175);
    // din equal to level is a release
    send(23'h3C0000);
    check("eq_release", 32'(level), 32'h384000);

    // Small-level decay: 3 -> 2 -> 1 -> 0 -> 0
    do_reset();
    send(23'd3);
    check("lvl3_code", 32'(level_code), 32'd12);
    send(23'd0);
    check("lvl2", 32'(level), 32'd2);
    check("lvl2_code", 32'(level_code), 32'd8);
    send(23'd0);
    check("lvl1", 32'(level), 32'd1);
    check("lvl1_code", 32'(level_code), 32'd0);
    send(23'd0);
    check("lvl0", 32'(level), 32'd0);
    send(23'd0);
    check("lvl0_stay", 32'(level), 32'd0);
    check("lvl0_code", 32'(level_code), 32'd0);

    // Back-to-back strobes
    do_reset();
    @(negedge clk);
    vin = 1'b1; din = 23'h000100;
    @(negedge clk);
    din = 23'h7FFFFF;
    check("b2b_l1", 32'(level), 32'h100);
    check("b2b_v0", 32'(vout), 32'd0);
    @(negedge clk);
    din = 23'd0;
    check("b2b_v1", 32'(vout), 32'd1);
    check("b2b_c1", 32'(level_code), 32'd64);
    @(negedge clk);
    vin = 1'b0;
    check("b2b_v2", 32'(vout), 32'd1);
    check("b2b_c2", 32'(level_code), 32'd183);
    check("b2b_l3", 32'(level), 32'h780000);
    @(negedge clk);
    check("b2b_v3", 32'(vout), 32'd1);
    check("b2b_c3", 32'(level_code), 32'd183);
    @(negedge clk);
    check("b2b_vend", 32'(vout), 32'd0);

    // Reset one cycle after vin discards the update
    do_reset();
    @(negedge clk);
    vin = 1'b1; din = 23'h7FFFFF;
    @(negedge clk);
    vin = 1'b0; din = 23'd0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_vout", 32'(vout), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_code", 32'(level_code), 32'd0);
    check("midrst_hold", 32'(hold_code), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_novout", 32'(vout), 32'd0);
    end
    model_reset();

    // Long release for hold marker tracking
    send(23'h7FFFFF);
    check("hold_fs", 32'(hold_code), 32'(m_hold));
    for (int k = 0; k < 40; k++) begin
      send(23'd0);
`ifdef METER_PEAK_HOLD_EN
      check("hold_ge_code", 32'(hold_code >= level_code), 32'd1);
`else
      check("hold_tied0", 32'(hold_code), 32'd0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
